// File: rtl/ushift_reg_n_if.sv
// Control and data bundle of the universal shift register; the controller
// drives it through master, the shifter sits on slave.
interface ushift_reg_n_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
);
  logic [WIDTH-1:0] PData;
  logic [1:0]       S;
  logic [1:0]       M;
  logic             SR;
  logic             SL;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] Q;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output PData, S, M, SR, SL, start, amount,
    input  Q, ser_out, busy, done
  );

  modport slave (
    input  PData, S, M, SR, SL, start, amount,
    output Q, ser_out, busy, done
  );
endinterface

// File: rtl/ushift_reg_n.sv
// Universal shift register with fill modes and a counted multi-step shift engine.
// Direct ops take effect on the sampling edge; a counted shift of N runs N+1 cycles.
module ushift_reg_n #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           clear,
  ushift_reg_n_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic             so, so_nxt;
  logic             done_q, done_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       dir, dir_nxt;
  logic [1:0]       mode, mode_nxt;
  logic             sr_l, sr_l_nxt;
  logic             sl_l, sl_l_nxt;
  logic [WIDTH:0]   stp;

  // One single-bit shift; returns {bit shifted out, new register value}.
  function automatic logic [WIDTH:0] step(
    input logic [WIDTH-1:0] v,
    input logic [1:0]       d,
    input logic [1:0]       md,
    input logic             sri,
    input logic             sli
  );
    logic fill;
    if (d == 2'b01) begin
      case (md)
        2'b00:   fill = sri;
        2'b01:   fill = v[0];
        2'b10:   fill = v[WIDTH-1];
        default: fill = 1'b0;
      endcase
      step = {v[0], fill, v[WIDTH-1:1]};
    end else begin
      case (md)
        2'b00:   fill = sli;
        2'b01:   fill = v[WIDTH-1];
        default: fill = 1'b0;
      endcase
      step = {v[WIDTH-1], v[WIDTH-2:0], fill};
    end
  endfunction

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    so_nxt    = so;
    done_nxt  = 1'b0;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    mode_nxt  = mode;
    sr_l_nxt  = sr_l;
    sl_l_nxt  = sl_l;
    stp       = '0;
    case (state)
      IDLE: begin
        if (bus.start && (bus.S == 2'b01 || bus.S == 2'b10)) begin
          if (bus.amount == '0) begin
            done_nxt = 1'b1;
          end else begin
            dir_nxt   = bus.S;
            mode_nxt  = bus.M;
            sr_l_nxt  = bus.SR;
            sl_l_nxt  = bus.SL;
            cnt_nxt   = bus.amount;
            state_nxt = SHIFT;
          end
        end else begin
          case (bus.S)
            2'b01, 2'b10: begin
              stp    = step(q, bus.S, bus.M, bus.SR, bus.SL);
              q_nxt  = stp[WIDTH-1:0];
              so_nxt = stp[WIDTH];
            end
            2'b11:   q_nxt = bus.PData;
            default: ;
          endcase
        end
      end
      SHIFT: begin
        // All bus inputs are ignored here; only the latched command matters.
        stp     = step(q, dir, mode, sr_l, sl_l);
        q_nxt   = stp[WIDTH-1:0];
        so_nxt  = stp[WIDTH];
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state  <= IDLE;
      q      <= '0;
      so     <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
      dir    <= 2'b00;
      mode   <= 2'b00;
      sr_l   <= 1'b0;
      sl_l   <= 1'b0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      so     <= so_nxt;
      done_q <= done_nxt;
      cnt    <= cnt_nxt;
      dir    <= dir_nxt;
      mode   <= mode_nxt;
      sr_l   <= sr_l_nxt;
      sl_l   <= sl_l_nxt;
    end
  end

  assign bus.Q       = q;
  assign bus.ser_out = so;
  assign bus.busy    = (state == SHIFT);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_ushift_reg_n.sv
// Bench for ushift_reg_n: three widths (8/16/32) side by side, each tracked by
// a per-edge behavioural model; directed scenarios followed by random traffic.
module tb_ushift_reg_n;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  ushift_reg_n_if #(.WIDTH(8),  .CNT_W(6)) if8  ();
  ushift_reg_n_if #(.WIDTH(16), .CNT_W(6)) if16 ();
  ushift_reg_n_if #(.WIDTH(32), .CNT_W(6)) if32 ();

  ushift_reg_n #(.WIDTH(8),  .CNT_W(6)) u8  (.clk(clk), .clear(clear), .bus(if8));
  ushift_reg_n #(.WIDTH(16), .CNT_W(6)) u16 (.clk(clk), .clear(clear), .bus(if16));
  ushift_reg_n #(.WIDTH(32), .CNT_W(6)) u32 (.clk(clk), .clear(clear), .bus(if32));

  int errors = 0;
  int checks = 0;
  int unsigned wid [3] = '{8, 16, 32};

  logic [31:0] pd [3];
  logic [1:0]  s [3], m [3];
  logic        sr [3], sl [3], st [3];
  logic [5:0]  amt [3];

  logic [31:0] mq [3];
  logic        mso [3], mbusy [3], mdone [3];
  int          mrem [3];
  logic [1:0]  mdir [3], mmode [3];
  logic        msr [3], msl [3];

  assign if8.PData  = pd[0][7:0];  assign if8.S  = s[0]; assign if8.M  = m[0];
  assign if8.SR     = sr[0];       assign if8.SL = sl[0];
  assign if8.start  = st[0];       assign if8.amount  = amt[0];
  assign if16.PData = pd[1][15:0]; assign if16.S = s[1]; assign if16.M = m[1];
  assign if16.SR    = sr[1];       assign if16.SL = sl[1];
  assign if16.start = st[1];       assign if16.amount = amt[1];
  assign if32.PData = pd[2];       assign if32.S = s[2]; assign if32.M = m[2];
  assign if32.SR    = sr[2];       assign if32.SL = sl[2];
  assign if32.start = st[2];       assign if32.amount = amt[2];

  function automatic logic [31:0] dq(input int k);
    case (k)
      0:       return 32'(if8.Q);
      1:       return 32'(if16.Q);
      default: return if32.Q;
    endcase
  endfunction

  function automatic logic [3:0] dflags(input int k);
    case (k)
      0:       return {if8.ser_out,  if8.busy,  if8.done,  1'b0};
      1:       return {if16.ser_out, if16.busy, if16.done, 1'b0};
      default: return {if32.ser_out, if32.busy, if32.done, 1'b0};
    endcase
  endfunction

  function automatic logic dbusy(input int k);
    logic [3:0] f;
    f = dflags(k);
    return f[2];
  endfunction

  function automatic logic ddone(input int k);
    logic [3:0] f;
    f = dflags(k);
    return f[1];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] msk(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Arithmetic reference of one shift: returns {bit leaving, new value}.
  function automatic logic [32:0] shift1(input logic [31:0] q, input int unsigned w,
                                         input logic [1:0] d, input logic [1:0] md,
                                         input logic sri, input logic sli);
    logic        msb, lsb, fill;
    logic [31:0] f32, nq;
    msb = q[w-1];
    lsb = q[0];
    if (d == 2'b01) begin
      fill = (md == 2'b00) ? sri : (md == 2'b01) ? lsb : (md == 2'b10) ? msb : 1'b0;
      f32  = 32'(fill);
      nq   = (q >> 1) | (f32 << (w - 1));
      return {lsb, nq};
    end
    fill = (md == 2'b00) ? sli : (md == 2'b01) ? msb : 1'b0;
    f32  = 32'(fill);
    nq   = ((q << 1) | f32) & msk(w);
    return {msb, nq};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k] = '0; mso[k] = 1'b0; mbusy[k] = 1'b0; mdone[k] = 1'b0; mrem[k] = 0;
    end
  endtask

  task automatic model_edge(input int k);
    logic [32:0] r;
    mdone[k] = 1'b0;
    if (mbusy[k]) begin
      r = shift1(mq[k], wid[k], mdir[k], mmode[k], msr[k], msl[k]);
      mq[k] = r[31:0]; mso[k] = r[32];
      mrem[k]--;
      if (mrem[k] == 0) begin
        mbusy[k] = 1'b0; mdone[k] = 1'b1;
      end
    end else if (st[k] && (s[k] == 2'b01 || s[k] == 2'b10)) begin
      if (amt[k] == 6'd0) mdone[k] = 1'b1;
      else begin
        mdir[k] = s[k]; mmode[k] = m[k]; msr[k] = sr[k]; msl[k] = sl[k];
        mrem[k] = int'(amt[k]); mbusy[k] = 1'b1;
      end
    end else if (s[k] == 2'b11) begin
      mq[k] = pd[k] & msk(wid[k]);
    end else if (s[k] != 2'b00) begin
      r = shift1(mq[k], wid[k], s[k], m[k], sr[k], sl[k]);
      mq[k] = r[31:0]; mso[k] = r[32];
    end
  endtask

  task automatic check_all(input int k);
    logic [3:0] f;
    f = dflags(k);
    check($sformatf("w%0d.Q", wid[k]),       dq(k),       mq[k]);
    check($sformatf("w%0d.ser_out", wid[k]), 32'(f[3]),   32'(mso[k]));
    check($sformatf("w%0d.busy", wid[k]),    32'(f[2]),   32'(mbusy[k]));
    check($sformatf("w%0d.done", wid[k]),    32'(f[1]),   32'(mdone[k]));
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    for (int k = 0; k < 3; k++) check_all(k);
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      pd[k] = '0; s[k] = 2'b00; m[k] = 2'b00; sr[k] = 1'b0; sl[k] = 1'b0;
      st[k] = 1'b0; amt[k] = '0;
    end
  endtask

  // Asserted mid-cycle: outputs must clear with no clock edge in between.
  task automatic do_reset();
    clear = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      check_all(k);
      check($sformatf("w%0d.rst_q", wid[k]), dq(k), 32'd0);
    end
    @(negedge clk);
    clear = 1'b1;
  endtask

  task automatic load(input int k, input logic [31:0] v);
    pd[k] = v; s[k] = 2'b11;
    cycle();
    s[k] = 2'b00;
  endtask

  // Runs a command already set up on instance k until done; optionally
  // drives load/restart noise on the bus while busy.
  task automatic run_cmd(input int k, input bit noisy, output int nbusy, output int ndone);
    bit seen;
    seen = 1'b0; nbusy = 0; ndone = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      cycle();
      st[k] = 1'b0; s[k] = 2'b00;
      if (dbusy(k)) begin
        nbusy++;
        if (noisy) begin s[k] = 2'b11; pd[k] = '1; st[k] = 1'b1; end
      end
      if (ddone(k)) begin ndone++; seen = 1'b1; end
    end
    check("done_seen", 32'(seen), 32'd1);
    cycle();
    if (ddone(k)) ndone++;
  endtask

  int nb, nd;

  initial begin
    clear = 1'b0;
    idle_all();
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) check_all(k);
    @(negedge clk);
    clear = 1'b1;

    // Load then asynchronous clear
    load(0, 32'hA5);
    check("load_a5", dq(0), 32'hA5);
    #2;
    do_reset();

    // 194-style serial right shift on 32 bits
    load(2, 32'h8000_0001);
    s[2] = 2'b01; m[2] = 2'b00; sr[2] = 1'b1;
    cycle();
    check("ser1_q", dq(2), 32'hC000_0000);
    check("ser1_so", 32'(dflags(2) >> 3), 32'd1);
    cycle();
    check("ser2_q", dq(2), 32'hE000_0000);
    check("ser2_so", 32'(dflags(2) >> 3), 32'd0);
    idle_all();

    // Counted rotate left, then an amount larger than the width
    load(0, 32'h81);
    s[0] = 2'b10; m[0] = 2'b01; amt[0] = 6'd3; st[0] = 1'b1;
    run_cmd(0, 1'b0, nb, nd);
    check("rot3_busy", nb, 3); check("rot3_done", nd, 1); check("rot3_q", dq(0), 32'h0C);
    s[0] = 2'b10; m[0] = 2'b01; amt[0] = 6'd11; st[0] = 1'b1;
    run_cmd(0, 1'b0, nb, nd);
    check("rot11_busy", nb, 11); check("rot11_done", nd, 1); check("rot11_q", dq(0), 32'h60);

    // Arithmetic versus zero fill right shift on 16 bits
    load(1, 32'h8F00);
    s[1] = 2'b01; m[1] = 2'b10; amt[1] = 6'd4; st[1] = 1'b1;
    run_cmd(1, 1'b0, nb, nd);
    check("asr_q", dq(1), 32'hF8F0);
    load(1, 32'h8F00);
    s[1] = 2'b01; m[1] = 2'b11; amt[1] = 6'd4; st[1] = 1'b1;
    run_cmd(1, 1'b0, nb, nd);
    check("lsr_q", dq(1), 32'h08F0);

    // Bus noise while busy, then a zero-length command
    load(0, 32'h3C);
    s[0] = 2'b01; m[0] = 2'b01; amt[0] = 6'd5; st[0] = 1'b1;
    run_cmd(0, 1'b1, nb, nd);
    check("noisy_busy", nb, 5); check("noisy_done", nd, 1); check("noisy_q", dq(0), 32'hE1);
    s[0] = 2'b10; amt[0] = 6'd0; st[0] = 1'b1;
    cycle();
    check("amt0_done", 32'(ddone(0)), 32'd1);
    check("amt0_busy", 32'(dbusy(0)), 32'd0);
    check("amt0_q", dq(0), 32'hE1);
    st[0] = 1'b0; s[0] = 2'b00;
    cycle();
    check("amt0_done_drop", 32'(ddone(0)), 32'd0);

    // Reset aborts a counted shift; the next one runs its full count
    load(0, 32'h5A);
    s[0] = 2'b10; m[0] = 2'b00; sl[0] = 1'b1; amt[0] = 6'd5; st[0] = 1'b1;
    cycle();
    st[0] = 1'b0; s[0] = 2'b00;
    cycle();
    cycle();
    #2;
    do_reset();
    check("abort_busy", 32'(dbusy(0)), 32'd0);
    s[0] = 2'b10; m[0] = 2'b00; sl[0] = 1'b1; amt[0] = 6'd5; st[0] = 1'b1;
    run_cmd(0, 1'b0, nb, nd);
    check("rerun_busy", nb, 5); check("rerun_done", nd, 1); check("rerun_q", dq(0), 32'h1F);
    idle_all();

    // Random traffic on all three widths
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 3; k++) begin
        pd[k]  = $urandom;
        s[k]   = 2'($urandom_range(0, 3));
        m[k]   = 2'($urandom_range(0, 3));
        sr[k]  = 1'($urandom_range(0, 1));
        sl[k]  = 1'($urandom_range(0, 1));
        st[k]  = ($urandom_range(0, 3) == 0);
        amt[k] = 6'($urandom_range(0, 40));
      end
      cycle();
      if (i == 200) begin
        #2;
        do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
